cl_rx_word_align: RTL
=====================

Name: cl_rx_word_align

Overview:
- Sits directly downstream of the IO clock divider and the 1:7 input deserializers on the CameraLink receive path.
- Runs on the divided word clock.
- Takes the raw 7-bit words from the forwarded-clock lane and four data lanes, and finds the word boundary by matching the clock-lane pattern.
- Rotates all lanes by the same offset and presents frame-aligned 28-bit words with a lock indication to the pixel unpacker.

Parameters:
CLK_PATTERN, 7'b1100011, expected clock-lane word when correctly aligned (MSB first)
LOCK_CNT, 16, consecutive matching words required to declare lock (range 1..255)
UNLOCK_CNT, 4, consecutive mismatching words in LOCKED that drop lock (range 1..255)

Ports:
CLKIN  input  1  divided word clock; all logic on rising edge
RST  input  1  synchronous active-high reset
IN_VALID  input  1  raw words valid this cycle
IN_CLK_WORD  input  7  raw clock-lane word, bit 6 earliest-received
IN_DATA_WORD  input  28  raw data lanes; lane n in bits [7n+6:7n], bit 6 of each lane earliest
OUT_VALID  output  1  aligned word valid (only while locked)
OUT_DATA  output  28  aligned data lanes, same lane packing
OUT_OFFSET  output  3  current rotation offset 0..6
LOCKED  output  1  alignment locked
LOCK_LOST  output  1  one-cycle pulse when LOCKED falls

Behaviour:
- Reset (RST=1 at a clock edge) sets:
  - state=SEARCH, offset=0, good_cnt=0, bad_cnt=0;
  - previous-word registers=0, OUT_VALID=0, OUT_DATA=0, LOCKED=0, LOCK_LOST=0.
- Reset mid-operation aborts any lock immediately. LOCK_LOST is not pulsed by reset.
- Windows: per lane, win = {prev_word, cur_word} (14 bits). The selected word at offset k is win[13-k:7-k].
  - k=0 selects prev_word.
  - k=6 selects prev[0] concatenated with cur[6:1].
- The same k applies to the clock lane and all four data lanes.
- prev_word registers load the current raw words only on cycles with IN_VALID=1. Cycles with IN_VALID=0 change no state at all.
- match = (selected clock-lane word == CLK_PATTERN), evaluated with the offset held at the start of the cycle.
- FSM, evaluated only when IN_VALID=1:
  - SEARCH:
    - match: good_cnt=1; go to VERIFY, or straight to LOCKED if LOCK_CNT==1.
    - no match: offset = (offset==6) ? 0 : offset+1.
  - VERIFY:
    - match: good_cnt++; when good_cnt reaches LOCK_CNT, go to LOCKED and clear bad_cnt.
    - no match: go to SEARCH, offset advances by 1 modulo 7, good_cnt=0.
  - LOCKED:
    - match: bad_cnt=0.
    - no match: bad_cnt++; when bad_cnt reaches UNLOCK_CNT, go to SEARCH, advance offset modulo 7, bad_cnt=0, and pulse LOCK_LOST for one cycle.
- LOCKED output = (state==LOCKED), registered.
- Latency: OUT_DATA/OUT_VALID are registered one clock after the IN_VALID cycle that produced the window.
  - OUT_VALID=1 iff IN_VALID=1 in that cycle and the state at the start of that cycle was LOCKED.
  - Hence the word that completes lock is not output, and the word that causes lock loss is still output.
- OUT_DATA is updated on every IN_VALID cycle regardless of lock. OUT_DATA is don't-care when OUT_VALID=0.
- OUT_OFFSET reflects the registered offset. Offset is only modified in SEARCH or on the transitions into SEARCH listed above, so it is frozen in VERIFY and LOCKED.
- Counters:
  - good_cnt and bad_cnt are 8 bits wide and saturate.
  - A LOCK_CNT/UNLOCK_CNT setting of 0 is illegal; a simulation-only parameter check prints an error.
- Worst-case search: at most 7 consecutive valid words without a match cycle through every offset.

Test Plan:
- **Aligned at offset 3.** Raw clock-lane stream is the bit-continuous repetition of 1100011, shifted so that alignment needs k=3; data lanes carry a known incrementing pattern.
  - Required: LOCKED rises after 3 search words + 16 matches.
  - OUT_OFFSET=3.
  - OUT_DATA equals the transmitted words, rotated identically on all four lanes.
- **Glitch tolerance.** While locked, inject 3 consecutive corrupted clock words, then a good one.
  - Required: LOCKED stays 1, no LOCK_LOST, bad_cnt returns to 0.
- **Lock loss.** While locked, inject 4 consecutive corrupted clock words.
  - Required: LOCK_LOST pulses exactly once.
  - LOCKED=0 on the next cycle.
  - OUT_OFFSET advances by 1 modulo 7 (6 wraps to 0).
  - Search resumes.
- **VERIFY abort.** Match at offset 5, then a mismatch on the 10th word.
  - Required: return to SEARCH with offset 6, no LOCKED, no OUT_VALID.
- **IN_VALID gaps.** Alternate IN_VALID 1/0 during search and lock.
  - Required: the lock word count counts valid cycles only.
  - OUT_VALID never asserts in a cycle following IN_VALID=0.
  - Result is identical to the gap-free run.
- **Reset mid-lock and parameter corners.** Assert RST for 1 cycle while locked.
  - Required: all outputs 0 next cycle and the search restarts from offset 0.
  - Repeat with LOCK_CNT=1, UNLOCK_CNT=1: lock on the first match, lose lock on the first mismatch.

Source files
------------

// File: rtl/cl_rx_word_align.sv
// -----------------------------------------------------------------------------
// cl_rx_word_align
//
// CameraLink receive word aligner. Sits behind the 1:7 input deserializers and
// runs on the divided word clock. The forwarded-clock lane carries a fixed
// 7-bit pattern. The block searches the seven possible bit rotations of that
// lane for the pattern, and verifies the match over LOCK_CNT consecutive
// words. It then applies the same rotation to all four data lanes and reports
// lock. UNLOCK_CNT consecutive clock-lane mismatches while locked drop lock
// and restart the search at the next rotation.
//
// Ports
//   CLKIN         divided word clock, all logic on the rising edge
//   RST           synchronous active-high reset
//   IN_VALID      raw words valid this cycle (no state changes when low)
//   IN_CLK_WORD   raw clock-lane word, bit 6 received first
//   IN_DATA_WORD  raw data lanes, lane n in [7n+6:7n], bit 6 received first
//   OUT_VALID     aligned word valid (only for words taken while locked)
//   OUT_DATA      aligned data lanes, same packing as IN_DATA_WORD
//   OUT_OFFSET    current rotation offset 0..6
//   LOCKED        alignment locked
//   LOCK_LOST     one-cycle pulse when LOCKED falls (not on reset)
// -----------------------------------------------------------------------------
module cl_rx_word_align #(
   parameter logic [6:0] CLK_PATTERN = 7'b1100011,
   parameter int         LOCK_CNT    = 16,
   parameter int         UNLOCK_CNT  = 4
) (
   input  logic        CLKIN,
   input  logic        RST,
   input  logic        IN_VALID,
   input  logic [6:0]  IN_CLK_WORD,
   input  logic [27:0] IN_DATA_WORD,
   output logic        OUT_VALID,
   output logic [27:0] OUT_DATA,
   output logic [2:0]  OUT_OFFSET,
   output logic        LOCKED,
   output logic        LOCK_LOST
);

   localparam logic [7:0] LOCK_CNT_W   = 8'(LOCK_CNT);
   localparam logic [7:0] UNLOCK_CNT_W = 8'(UNLOCK_CNT);

   // Out-of-range counts cannot be represented by the 8-bit counters.
   generate
      if ((LOCK_CNT < 1) || (LOCK_CNT > 255)) begin : g_lock_cnt_bad
         $error("cl_rx_word_align: LOCK_CNT must be in 1..255");
      end
      if ((UNLOCK_CNT < 1) || (UNLOCK_CNT > 255)) begin : g_unlock_cnt_bad
         $error("cl_rx_word_align: UNLOCK_CNT must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  offset_reg, offset_next;
   logic [7:0]  good_cnt_reg, good_cnt_next;
   logic [7:0]  bad_cnt_reg, bad_cnt_next;
   logic [6:0]  prev_clk_reg;
   logic [27:0] prev_data_reg;
   logic        out_valid_reg, out_valid_next;
   logic [27:0] out_data_reg;
   logic        lock_lost_reg, lock_lost_next;

   logic [6:0]  clk_sel;
   logic [27:0] data_sel;
   logic        match;
   logic [2:0]  offset_inc;
   logic [7:0]  good_inc;
   logic [7:0]  bad_inc;

   // Offset k picks win[13-k:7-k] of {prev, cur}. Shifting the window left
   // by k moves that slice to the top 7 bits.
   function automatic logic [6:0] sel_word(input logic [6:0] prev,
                                           input logic [6:0] cur,
                                           input logic [2:0] k);
      logic [13:0] win;
      win = {prev, cur} << k;
      return win[13:7];
   endfunction

   assign clk_sel = sel_word(prev_clk_reg, IN_CLK_WORD, offset_reg);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign data_sel[7*gi +: 7] = sel_word(prev_data_reg[7*gi +: 7],
                                               IN_DATA_WORD[7*gi +: 7],
                                               offset_reg);
      end
   endgenerate

   assign match      = (clk_sel == CLK_PATTERN);
   assign offset_inc = (offset_reg == 3'd6) ? 3'd0 : offset_reg + 3'd1;
   assign good_inc   = (good_cnt_reg == 8'hFF) ? 8'hFF : good_cnt_reg + 8'd1;
   assign bad_inc    = (bad_cnt_reg == 8'hFF) ? 8'hFF : bad_cnt_reg + 8'd1;

   // State register and datapath registers
   always_ff @(posedge CLKIN) begin
      if (RST) begin
         state_reg     <= ST_SEARCH;
         offset_reg    <= 3'd0;
         good_cnt_reg  <= 8'd0;
         bad_cnt_reg   <= 8'd0;
         prev_clk_reg  <= 7'd0;
         prev_data_reg <= 28'd0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= 28'd0;
         lock_lost_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         offset_reg    <= offset_next;
         good_cnt_reg  <= good_cnt_next;
         bad_cnt_reg   <= bad_cnt_next;
         out_valid_reg <= out_valid_next;
         lock_lost_reg <= lock_lost_next;
         if (IN_VALID) begin
            prev_clk_reg  <= IN_CLK_WORD;
            prev_data_reg <= IN_DATA_WORD;
            out_data_reg  <= data_sel;
         end
      end
   end

   // Next-state logic; everything holds on cycles without valid words.
   always_comb begin
      state_next    = state_reg;
      offset_next   = offset_reg;
      good_cnt_next = good_cnt_reg;
      bad_cnt_next  = bad_cnt_reg;
      if (IN_VALID) begin
         case (state_reg)
            ST_SEARCH: begin
               if (match) begin
                  good_cnt_next = 8'd1;
                  if (LOCK_CNT_W == 8'd1) begin
                     state_next   = ST_LOCKED;
                     bad_cnt_next = 8'd0;
                  end else begin
                     state_next = ST_VERIFY;
                  end
               end else begin
                  offset_next = offset_inc;
               end
            end
            ST_VERIFY: begin
               if (match) begin
                  good_cnt_next = good_inc;
                  if (good_inc >= LOCK_CNT_W) begin
                     state_next   = ST_LOCKED;
                     bad_cnt_next = 8'd0;
                  end
               end else begin
                  state_next    = ST_SEARCH;
                  offset_next   = offset_inc;
                  good_cnt_next = 8'd0;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  bad_cnt_next = 8'd0;
               end else begin
                  bad_cnt_next = bad_inc;
                  if (bad_inc >= UNLOCK_CNT_W) begin
                     state_next    = ST_SEARCH;
                     offset_next   = offset_inc;
                     bad_cnt_next  = 8'd0;
                     good_cnt_next = 8'd0;
                  end
               end
            end
            default: begin
               state_next    = ST_SEARCH;
               offset_next   = 3'd0;
               good_cnt_next = 8'd0;
               bad_cnt_next  = 8'd0;
            end
         endcase
      end
   end

   // Output decode. The validity of a word depends on the state at the start
   // of its cycle, so the lock-completing word is suppressed and the word
   // that breaks lock is still delivered.
   always_comb begin
      out_valid_next = IN_VALID && (state_reg == ST_LOCKED);
      lock_lost_next = IN_VALID && (state_reg == ST_LOCKED) &&
                       (state_next == ST_SEARCH);
   end

   assign OUT_VALID  = out_valid_reg;
   assign OUT_DATA   = out_data_reg;
   assign OUT_OFFSET = offset_reg;
   assign LOCKED     = (state_reg == ST_LOCKED);
   assign LOCK_LOST  = lock_lost_reg;

endmodule
